// File: rtl/instr_encoder_if.sv
// Request handshake and instruction-memory write bus for instr_encoder.
// master = instruction producer / memory side, slave = the encoder.
interface instr_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [31:0]       in_imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_imm,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder.sv
// Sequential MIPS instruction encoder writing machine words to instruction memory.
// Define ENC_RANGE_CHECK_EN to enable immediate-range and jump/branch target checks.
module instr_encoder #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  instr_encoder_if.slave    bus,
  input  logic              restart,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_code
);

`ifdef ENC_RANGE_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  localparam logic [ADDR_W:0] CAP = (ADDR_W+1)'(1) << ADDR_W;

  typedef enum logic [3:0] {
    OP_LW   = 4'd0,
    OP_SW   = 4'd1,
    OP_J    = 4'd2,
    OP_JR   = 4'd3,
    OP_JAL  = 4'd4,
    OP_BNE  = 4'd5,
    OP_XORI = 4'd6,
    OP_ADD  = 4'd7,
    OP_SUB  = 4'd8,
    OP_SLT  = 4'd9,
    OP_ADDI = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENC,
    S_WRITE,
    S_ERR
  } state_e;

  localparam logic [1:0] ERR_OP  = 2'b01;
  localparam logic [1:0] ERR_IMM = 2'b10;
  localparam logic [1:0] ERR_TGT = 2'b11;

  function automatic logic fits_s16(input logic signed [31:0] v);
    return (v[31:15] == '0) || (v[31:15] == '1);
  endfunction

  function automatic logic fits_u16(input logic [31:0] v);
    return v[31:16] == '0;
  endfunction

  state_e state;
  logic   accept;

  // Stage p0: request captured at accept
  logic [3:0]  op_p0;
  logic [4:0]  rs_p0, rt_p0, rd_p0;
  logic [31:0] imm_p0;

  assign full         = (count == CAP);
  assign bus.in_ready = (state == S_IDLE) && !full && !restart && !reset;
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0  <= bus.in_op;
      rs_p0  <= bus.in_rs;
      rt_p0  <= bus.in_rt;
      rd_p0  <= bus.in_rd;
      imm_p0 <= bus.in_imm;
    end
  end

  // Stage p1: encode and check during ENC
  logic [31:0]        pc_p1, pc4_p1;
  logic signed [31:0] br_diff_p1, br_off_p1;
  logic               simm_bad_p1, uimm_bad_p1, mis_p1, region_bad_p1, off_bad_p1;
  logic [31:0]        word_p1;
  logic               fault_p1;
  logic [1:0]         code_p1;

  assign pc_p1      = BASE_ADDR + (32'(count) << 2);
  assign pc4_p1     = pc_p1 + 32'd4;
  assign br_diff_p1 = $signed(imm_p0 - pc4_p1);
  assign br_off_p1  = br_diff_p1 >>> 2;

  assign simm_bad_p1   = !fits_s16(imm_p0);
  assign uimm_bad_p1   = !fits_u16(imm_p0);
  assign mis_p1        = (imm_p0[1:0] != 2'b00);
  assign region_bad_p1 = (imm_p0[31:28] != pc4_p1[31:28]);
  assign off_bad_p1    = !fits_s16(br_off_p1);

  always_comb begin
    word_p1  = '0;
    fault_p1 = 1'b0;
    code_p1  = 2'b00;
    case (op_p0)
      OP_ADD:  word_p1 = {6'h00, rs_p0, rt_p0, rd_p0, 5'h00, 6'h20};
      OP_SUB:  word_p1 = {6'h00, rs_p0, rt_p0, rd_p0, 5'h00, 6'h22};
      OP_SLT:  word_p1 = {6'h00, rs_p0, rt_p0, rd_p0, 5'h00, 6'h2A};
      OP_JR:   word_p1 = {6'h00, rs_p0, 15'h0000, 6'h08};
      OP_LW, OP_SW, OP_ADDI: begin
        case (op_p0)
          OP_LW:   word_p1 = {6'h23, rs_p0, rt_p0, imm_p0[15:0]};
          OP_SW:   word_p1 = {6'h2B, rs_p0, rt_p0, imm_p0[15:0]};
          default: word_p1 = {6'h08, rs_p0, rt_p0, imm_p0[15:0]};
        endcase
        if (CHK_EN && simm_bad_p1) begin
          fault_p1 = 1'b1;
          code_p1  = ERR_IMM;
        end
      end
      OP_XORI: begin
        word_p1 = {6'h0E, rs_p0, rt_p0, imm_p0[15:0]};
        if (CHK_EN && uimm_bad_p1) begin
          fault_p1 = 1'b1;
          code_p1  = ERR_IMM;
        end
      end
      OP_J, OP_JAL: begin
        word_p1 = {(op_p0 == OP_J) ? 6'h02 : 6'h03, imm_p0[27:2]};
        if (CHK_EN && (mis_p1 || region_bad_p1)) begin
          fault_p1 = 1'b1;
          code_p1  = ERR_TGT;
        end
      end
      OP_BNE: begin
        // Low target bits fall out of the arithmetic shift when misaligned.
        word_p1 = {6'h05, rs_p0, rt_p0, br_off_p1[15:0]};
        if (CHK_EN && (mis_p1 || off_bad_p1)) begin
          fault_p1 = 1'b1;
          code_p1  = ERR_TGT;
        end
      end
      default: begin
        fault_p1 = 1'b1;
        code_p1  = ERR_OP;
      end
    endcase
  end

  // Stage p2: memory write strobe, count and error registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      count         <= '0;
      err           <= 1'b0;
      err_code      <= 2'b00;
    end else begin
      bus.mem_we <= 1'b0;
      if (restart) begin
        // A write already on the bus completes; only bookkeeping is cleared.
        state    <= S_IDLE;
        count    <= '0;
        err      <= 1'b0;
        err_code <= 2'b00;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) state <= S_ENC;
          end
          S_ENC: begin
            if (fault_p1) begin
              err      <= 1'b1;
              err_code <= code_p1;
              state    <= S_ERR;
            end else begin
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= count[ADDR_W-1:0];
              bus.mem_wdata <= word_p1;
              state         <= S_WRITE;
            end
          end
          S_WRITE: begin
            count <= count + (ADDR_W+1)'(1);
            state <= S_IDLE;
          end
          default: state <= S_ERR;
        endcase
      end
    end
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential MIPS instruction encoder for the single-cycle CPU's program-load path. It accepts one symbolic instruction per valid/ready handshake: an operation enum, register fields and an immediate or absolute target. It produces the 32-bit machine word, computes branch offsets and jump fields relative to the current load address, and writes the word into instruction memory at an auto-incrementing word address. It is the producer side of the CPU's instruction decoder.

## Interface
- `ADDR_W`, default 10: instruction-memory word-address width; capacity 2^ADDR_W words.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0; word aligned.
- `clk` input, 1: clock; all logic on rising edge.
- `reset` input, 1: synchronous, active-high.
- `in_valid` input, 1: request valid.
- `in_ready` output, 1: combinational; `(state==IDLE) && !full && !restart && !reset`.
- `in_op` input, 4: 0 LW, 1 SW, 2 J, 3 JR, 4 JAL, 5 BNE, 6 XORI, 7 ADD, 8 SUB, 9 SLT, 10 ADDI; 11–15 illegal.
- `in_rs`, `in_rt`, `in_rd` input, 5 each: register fields.
- `in_imm` input, 32: immediate for LW/SW/ADDI/XORI; absolute byte target for J/JAL/BNE.
- `restart` input, 1: clears write pointer, count and error.
- `mem_we` output, 1: registered one-cycle write strobe.
- `mem_addr` output, ADDR_W: registered word address.
- `mem_wdata` output, 32: registered encoded word.
- `count` output, ADDR_W+1: words written since reset/restart.
- `full` output, 1: `count == 2^ADDR_W`.
- `err` output, 1: sticky error flag.
- `err_code` output, 2: 01 illegal op, 10 immediate range, 11 target fault.

## Operation
- States: IDLE → ENC → WRITE → IDLE; any → ERR on fault; ERR → IDLE only on `restart`/`reset`.
- IDLE: on `in_valid && in_ready`, register all inputs; next state ENC.
- ENC: encode and check the request. Current PC = BASE_ADDR + 4·count (32-bit, wraps).
  - On fault: set `err`, load `err_code`, go to ERR; no write.
  - Otherwise: load `mem_wdata`; `mem_addr` = count[ADDR_W-1:0]; `mem_we` = 1; go to WRITE.
- WRITE: `mem_we` is high for exactly this cycle. `count` increments at the end of the cycle. Next state IDLE.
- Encodings (shamt always 0):
  - R-type: {6'h00, rs, rt, rd, 5'h00, funct}, with funct ADD 6'h20, SUB 6'h22, SLT 6'h2A.
  - JR: {6'h00, rs, 15'h0, 6'h08}.
  - I-type: {op, rs, rt, imm[15:0]}, with op LW 6'h23, SW 6'h2B, ADDI 6'h08, XORI 6'h0E.
  - BNE: op 6'h05; imm field = (target − (PC+4)) >>> 2, 16-bit two's complement.
  - J/JAL: {6'h02 or 6'h03, target[27:2]}.
- Checks (only the illegal op check is unconditional):
  - Illegal op → 01.
  - LW/SW/ADDI imm not in [−32768, 32767], or XORI imm > 16'hFFFF → 10.
  - J/JAL/BNE target[1:0] ≠ 0 → 11.
  - J/JAL target[31:28] ≠ (PC+4)[31:28] → 11.
  - BNE offset not representable in 16 bits → 11.
- Full: `in_ready` held low; a pending `in_valid` stalls; no error raised.
- `restart`:
  - Count clears to 0 and `err`/`err_code` clear to 0; state → IDLE.
  - In ENC: request aborted, no write.
  - In WRITE: the asserted write completes, but count clears to 0 rather than incrementing.
  - Same cycle as `in_valid`: restart wins, no accept.

## Timing
- Reset values: state IDLE, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `count` 0, `full` 0, `err` 0, `err_code` 0. `in_ready` is 0 while `reset` is high.
- Accept at edge T → ENC during cycle T+1 → `mem_we`=1 during cycle T+2 → `in_ready`=1 in cycle T+3 (if not full).
- Throughput: one word per 3 cycles.
- `count`/`full` update on the edge ending WRITE.
- `err` is visible in the cycle after ENC and holds until restart/reset.

## Configuration
- `ENC_RANGE_CHECK_EN` defined: all range and target checks active, with codes 10 and 11 as above.
- Not defined:
  - Only the illegal-op check remains.
  - Immediates and offsets are silently truncated to 16 bits.
  - J/JAL use target[27:2] regardless of region.
  - Misaligned targets drop bits [1:0].

## Test plan
- ADD rd=3 rs=1 rt=2, then LW rt=8 rs=29 imm=4 → `mem_wdata` 0x00221820 @ addr 0, then 0x8FA80004 @ addr 1. `mem_we` rises 2 cycles after each accept; count=2.
- BASE=0, two filler words, then BNE rs=1 rt=2 target 0x0 at word 2 → 0x1422FFFD @ addr 2.
- J target 0x40 → 0x08000010; JAL target 0x40 → 0x0C000010; JR rs=31 → 0x03E00008.
- XORI imm=0x10000:
  - Macro on → `err`=1, `err_code`=10, no `mem_we`, `in_ready` 0 until restart.
  - Macro off → 0x38000000 written (rs=rt=0).
- in_op=4'hF → `err_code`=01; restart → `err`=0, `in_ready`=1.
- ADDR_W=2, four ADDs → `full`=1, count=4, `in_ready` 0 with `in_valid` held. Restart asserted during a WRITE cycle → `mem_we` still pulses, count=0, next word goes to addr 0.
